// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mips_mem_arbiter - fair two-master arbiter for a fixed-latency memory port
// Revision: 1.0
// ==========================================================================
module mips_mem_arbiter #(
  parameter int AW     = 18,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          mem_wr_q, mem_wr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          grant;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    mem_wr_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the master that did not go last wins.
        grant = (m0_req && m1_req) ? ~last_q : m1_req;
        if (m0_req || m1_req) begin
          addr_d   = grant ? m1_addr  : m0_addr;
          wdata_d  = grant ? m1_wdata : m0_wdata;
          wr_d     = grant ? m1_wr    : m0_wr;
          mem_wr_d = grant ? m1_wr    : m0_wr;
          owner_d  = grant;
          cnt_d    = CNT_INIT;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = S_ACK;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (owner_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      mem_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      mem_wr_q <= mem_wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = mem_wr_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
`default_nettype wire
